// File: rtl/ahblite_master_engine.sv
// Command-driven AHB-Lite initiator: word transfers, SINGLE/INCR bursts,
// BUSY on write starvation, 1 KB re-NONSEQ and abort on error response.
module ahblite_master_engine (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        done_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    localparam int unsigned DW    = 32;
    localparam int unsigned REM_W = 5;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

    state_t            r_state, w_state_nxt;
    logic [DW-1:0]     r_haddr, w_haddr_nxt;
    logic [DW-1:0]     r_next_addr, w_next_addr_nxt;
    logic [1:0]        r_htrans, w_htrans_nxt;
    logic              r_hwrite, w_hwrite_nxt;
    logic [2:0]        r_hburst, w_hburst_nxt;
    logic [DW-1:0]     r_hwdata, w_hwdata_nxt;
    logic [DW-1:0]     r_wbuf, w_wbuf_nxt;
    logic [REM_W-1:0]  r_remaining, w_remaining_nxt;
    logic              r_first, w_first_nxt;
    logic              r_dphase, w_dphase_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic [DW-1:0]     r_rd_data, w_rd_data_nxt;
    logic              r_done, w_done_nxt;
    logic              r_done_err, w_done_err_nxt;

    logic              w_htrans_act;
    logic              w_err;
    logic              w_issue;

    assign w_htrans_act = r_htrans[1];
    assign w_err        = r_dphase && HRESP && !HREADY;
    assign w_issue      = (r_state == S_ADDR) && HREADY && (!r_hwrite || wr_valid);

    // State and datapath registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_haddr     <= '0;
            r_next_addr <= '0;
            r_htrans    <= TR_IDLE;
            r_hwrite    <= 1'b0;
            r_hburst    <= 3'b000;
            r_hwdata    <= '0;
            r_wbuf      <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_dphase    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_haddr     <= w_haddr_nxt;
            r_next_addr <= w_next_addr_nxt;
            r_htrans    <= w_htrans_nxt;
            r_hwrite    <= w_hwrite_nxt;
            r_hburst    <= w_hburst_nxt;
            r_hwdata    <= w_hwdata_nxt;
            r_wbuf      <= w_wbuf_nxt;
            r_remaining <= w_remaining_nxt;
            r_first     <= w_first_nxt;
            r_dphase    <= w_dphase_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_done      <= w_done_nxt;
            r_done_err  <= w_done_err_nxt;
        end
    end

    // Next-state, address-phase and data-phase logic
    always_comb begin
        w_state_nxt     = r_state;
        w_haddr_nxt     = r_haddr;
        w_next_addr_nxt = r_next_addr;
        w_htrans_nxt    = r_htrans;
        w_hwrite_nxt    = r_hwrite;
        w_hburst_nxt    = r_hburst;
        w_hwdata_nxt    = r_hwdata;
        w_wbuf_nxt      = r_wbuf;
        w_remaining_nxt = r_remaining;
        w_first_nxt     = r_first;
        w_dphase_nxt    = r_dphase;
        w_rd_valid_nxt  = 1'b0;
        w_rd_data_nxt   = r_rd_data;
        w_done_nxt      = 1'b0;
        w_done_err_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt     = S_ADDR;
                    w_next_addr_nxt = cmd_addr & 32'hFFFF_FFFC;
                    w_hwrite_nxt    = cmd_write;
                    w_hburst_nxt    = (cmd_len == 4'd0) ? 3'b000 : 3'b001;
                    w_remaining_nxt = REM_W'(cmd_len) + REM_W'(1);
                    w_first_nxt     = 1'b1;
                    w_htrans_nxt    = TR_IDLE;
                end
            end
            S_ADDR, S_LAST: begin
                if (w_err) begin
                    // Cancel any pending address phase during the error's first cycle
                    w_state_nxt  = S_ERR;
                    w_htrans_nxt = TR_IDLE;
                end else if (HREADY) begin
                    if (r_dphase && !r_hwrite && !HRESP) begin
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = HRDATA;
                    end
                    if (w_htrans_act && r_hwrite) begin
                        w_hwdata_nxt = r_wbuf;
                    end
                    w_dphase_nxt = w_htrans_act;
                    if (r_state == S_ADDR) begin
                        if (w_issue) begin
                            w_htrans_nxt    = (r_first || (r_next_addr[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
                            w_haddr_nxt     = r_next_addr;
                            w_next_addr_nxt = r_next_addr + 32'd4;
                            w_remaining_nxt = r_remaining - REM_W'(1);
                            w_first_nxt     = 1'b0;
                            if (r_hwrite) begin
                                w_wbuf_nxt = wr_data;
                            end
                            if (r_remaining == REM_W'(1)) begin
                                w_state_nxt = S_LAST;
                            end
                        end else begin
                            // Write data starved: nothing on the bus yet, or BUSY at the next address
                            w_htrans_nxt = r_first ? TR_IDLE : TR_BUSY;
                            w_haddr_nxt  = r_first ? r_haddr : r_next_addr;
                        end
                    end else begin
                        w_htrans_nxt = TR_IDLE;
                        if (r_dphase && !w_htrans_act) begin
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_IDLE;
                            w_dphase_nxt = 1'b0;
                        end
                    end
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    w_done_nxt     = 1'b1;
                    w_done_err_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                    w_dphase_nxt   = 1'b0;
                    w_htrans_nxt   = TR_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_ADDR) && r_hwrite && (r_remaining != REM_W'(0)) && HREADY;

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign done_err  = r_done_err;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = 3'b010;
    assign HBURST    = r_hburst;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahblite_master_engine.sv
// Directed bench for ahblite_master_engine: per-scenario cycle tables with
// hand-derived expected bus and stream activity.
module tb_ahblite_master_engine;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = '0;

    int n_checks = 0;
    int n_fail   = 0;

    ahblite_master_engine dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Presents the command in cycle T; returns at the sample point of T+1.
    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({HTRANS, HADDR, HWRITE, HBURST, HWDATA, rd_valid, rd_data, done, done_err, wr_ready, cmd_ready}
            !== {2'b00, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL reset_values got tr=%b a=%h cr=%b", HTRANS, HADDR, cmd_ready); end
        n_checks++;
        if ({HSIZE, HPROT, HMASTLOCK} !== {3'b010, 4'b0011, 1'b0})
            begin n_fail++; $display("FAIL constants got %b %b %b", HSIZE, HPROT, HMASTLOCK); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        n_checks++;
        if ({HTRANS, cmd_ready, done} !== {2'b00, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL reset_release got tr=%b cr=%b d=%b", HTRANS, cmd_ready, done); end
    endtask

    task automatic test_single_read(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea;
        ea = a & 32'hFFFF_FFFC;
        issue_cmd(1'b0, a, 4'd0);
        n_checks++;
        if ({HTRANS, cmd_ready} !== {2'b00, 1'b0})
            begin n_fail++; $display("FAIL sr_t1 got tr=%b cr=%b exp 00 0", HTRANS, cmd_ready); end
        step();
        n_checks++;
        if ({HTRANS, HADDR, HBURST, HWRITE} !== {2'b10, ea, 3'b000, 1'b0})
            begin n_fail++; $display("FAIL sr_t2 got tr=%b a=%h b=%b w=%b exp 10 %h 000 0", HTRANS, HADDR, HBURST, HWRITE, ea); end
        step();
        HRDATA = d;
        n_checks++;
        if ({HTRANS, rd_valid, done} !== {2'b00, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL sr_t3 got tr=%b rv=%b d=%b", HTRANS, rd_valid, done); end
        step();
        HRDATA = 32'h0;
        n_checks++;
        if ({rd_valid, rd_data, done, done_err, cmd_ready} !== {1'b1, d, 1'b1, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL sr_t4 got rv=%b rd=%h d=%b e=%b cr=%b exp 1 %h 1 0 1", rd_valid, rd_data, done, done_err, cmd_ready, d); end
        step();
        n_checks++;
        if ({rd_valid, done} !== 2'b00)
            begin n_fail++; $display("FAIL sr_t5 got rv=%b d=%b exp 0 0", rd_valid, done); end
    endtask

    task automatic test_write_starve();
        logic [1:0]  e_tr [1:8];
        logic [31:0] e_ad [1:8];
        logic        e_wm [1:8];
        logic [31:0] e_wd [1:8];
        logic        e_wr [1:8];
        logic        e_dn [1:8];
        logic        wv   [1:8];
        logic [31:0] wd   [1:8];
        e_tr = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        e_ad = '{32'h0, 32'h1000_0000, 32'h1000_0004, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C, 32'h0, 32'h0};
        e_wm = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_wd = '{32'h0, 32'h0, 32'h1111_1111, 32'h0, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0};
        e_wr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wv   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        wd   = '{32'h1111_1111, 32'h0, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0, 32'h0};
        issue_cmd(1'b1, 32'h1000_0000, 4'd3);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (HTRANS !== e_tr[k])
                begin n_fail++; $display("FAIL wr_htrans k=%0d got %b exp %b", k, HTRANS, e_tr[k]); end
            if (e_tr[k] != 2'b00) begin
                n_checks++;
                if (HADDR !== e_ad[k])
                    begin n_fail++; $display("FAIL wr_haddr k=%0d got %h exp %h", k, HADDR, e_ad[k]); end
            end
            if (e_wm[k]) begin
                n_checks++;
                if (HWDATA !== e_wd[k])
                    begin n_fail++; $display("FAIL wr_hwdata k=%0d got %h exp %h", k, HWDATA, e_wd[k]); end
            end
            n_checks++;
            if ({done, done_err} !== {e_dn[k], 1'b0})
                begin n_fail++; $display("FAIL wr_done k=%0d got %b%b exp %b0", k, done, done_err, e_dn[k]); end
            if (k == 2) begin
                n_checks++;
                if ({HWRITE, HBURST} !== {1'b1, 3'b001})
                    begin n_fail++; $display("FAIL wr_ctrl got w=%b b=%b exp 1 001", HWRITE, HBURST); end
            end
            wr_valid = wv[k];
            wr_data  = wd[k];
            #1;
            n_checks++;
            if (wr_ready !== e_wr[k])
                begin n_fail++; $display("FAIL wr_ready k=%0d got %b exp %b", k, wr_ready, e_wr[k]); end
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_read_wait();
        logic        hr   [1:9];
        logic [31:0] hd   [1:9];
        logic [1:0]  e_tr [1:9];
        logic [31:0] e_ad [1:9];
        logic        e_rv [1:9];
        logic [31:0] e_rd [1:9];
        logic        e_dn [1:9];
        hr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        hd   = '{32'h0, 32'h0, 32'h0A0A_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0B0B_0002, 32'h0C0C_0003, 32'h0, 32'h0};
        e_tr = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        e_ad = '{32'h0, 32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_0008, 32'h3000_0008, 32'h0, 32'h0, 32'h0};
        e_rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        e_rd = '{32'h0, 32'h0, 32'h0, 32'h0A0A_0001, 32'h0, 32'h0, 32'h0B0B_0002, 32'h0C0C_0003, 32'h0};
        e_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        issue_cmd(1'b0, 32'h3000_0000, 4'd2);
        for (int k = 1; k <= 9; k++) begin
            n_checks++;
            if (HTRANS !== e_tr[k])
                begin n_fail++; $display("FAIL rw_htrans k=%0d got %b exp %b", k, HTRANS, e_tr[k]); end
            if (e_tr[k] != 2'b00) begin
                n_checks++;
                if (HADDR !== e_ad[k])
                    begin n_fail++; $display("FAIL rw_haddr k=%0d got %h exp %h", k, HADDR, e_ad[k]); end
            end
            n_checks++;
            if ({rd_valid, done} !== {e_rv[k], e_dn[k]})
                begin n_fail++; $display("FAIL rw_valid_done k=%0d got %b%b exp %b%b", k, rd_valid, done, e_rv[k], e_dn[k]); end
            if (e_rv[k]) begin
                n_checks++;
                if (rd_data !== e_rd[k])
                    begin n_fail++; $display("FAIL rw_rdata k=%0d got %h exp %h", k, rd_data, e_rd[k]); end
            end
            HREADY = hr[k];
            HRDATA = hd[k];
            step();
        end
        HREADY = 1'b1;
        HRDATA = 32'h0;
    endtask

    task automatic test_error();
        logic        hr   [1:8];
        logic        hp   [1:8];
        logic [31:0] hd   [1:8];
        logic [1:0]  e_tr [1:8];
        logic [31:0] e_ad [1:8];
        logic        e_rv [1:8];
        logic        e_dn [1:8];
        int          n_rv;
        hr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        hp   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        hd   = '{32'h0, 32'h0, 32'h5555_AAAA, 32'hEEEE_EEEE, 32'hEEEE_EEEE, 32'h0, 32'h0, 32'h0};
        e_tr = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        e_ad = '{32'h0, 32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h0, 32'h0, 32'h0, 32'h0};
        e_rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        n_rv = 0;
        issue_cmd(1'b0, 32'h4000_0000, 4'd3);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (HTRANS !== e_tr[k])
                begin n_fail++; $display("FAIL er_htrans k=%0d got %b exp %b", k, HTRANS, e_tr[k]); end
            if (e_tr[k] != 2'b00) begin
                n_checks++;
                if (HADDR !== e_ad[k])
                    begin n_fail++; $display("FAIL er_haddr k=%0d got %h exp %h", k, HADDR, e_ad[k]); end
            end
            n_checks++;
            if ({rd_valid, done, done_err} !== {e_rv[k], e_dn[k], e_dn[k]})
                begin n_fail++; $display("FAIL er_flags k=%0d got %b%b%b exp %b%b%b", k, rd_valid, done, done_err, e_rv[k], e_dn[k], e_dn[k]); end
            if (e_rv[k]) begin
                n_checks++;
                if (rd_data !== 32'h5555_AAAA)
                    begin n_fail++; $display("FAIL er_rdata got %h exp 5555aaaa", rd_data); end
            end
            n_checks++;
            if (cmd_ready !== (k >= 6))
                begin n_fail++; $display("FAIL er_cmd_ready k=%0d got %b", k, cmd_ready); end
            if (rd_valid === 1'b1) n_rv++;
            HREADY = hr[k];
            HRESP  = hp[k];
            HRDATA = hd[k];
            step();
        end
        n_checks++;
        if (n_rv != 1)
            begin n_fail++; $display("FAIL er_rv_count got %0d exp 1", n_rv); end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
    endtask

    task automatic test_kb_split();
        logic [1:0]  e_tr [1:7];
        logic [31:0] e_ad [1:7];
        e_tr = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
        e_ad = '{32'h0, 32'h0000_03F8, 32'h0000_03FC, 32'h0000_0400, 32'h0000_0404, 32'h0, 32'h0};
        issue_cmd(1'b0, 32'h0000_03F8, 4'd3);
        for (int k = 1; k <= 7; k++) begin
            n_checks++;
            if (HTRANS !== e_tr[k])
                begin n_fail++; $display("FAIL kb_htrans k=%0d got %b exp %b", k, HTRANS, e_tr[k]); end
            if (e_tr[k] != 2'b00) begin
                n_checks++;
                if ({HADDR, HBURST} !== {e_ad[k], 3'b001})
                    begin n_fail++; $display("FAIL kb_haddr k=%0d got %h b=%b exp %h 001", k, HADDR, HBURST, e_ad[k]); end
            end
            n_checks++;
            if ({rd_valid, done} !== {(k >= 4), (k == 7)})
                begin n_fail++; $display("FAIL kb_flags k=%0d got rv=%b d=%b", k, rd_valid, done); end
            if (k >= 4) begin
                n_checks++;
                if (rd_data !== (32'hA000_0000 | 32'(k - 1)))
                    begin n_fail++; $display("FAIL kb_rdata k=%0d got %h exp %h", k, rd_data, 32'hA000_0000 | 32'(k - 1)); end
            end
            HRDATA = (k >= 3 && k <= 6) ? (32'hA000_0000 | 32'(k)) : 32'h0;
            step();
        end
        HRDATA = 32'h0;
    endtask

    task automatic test_reset_mid();
        issue_cmd(1'b0, 32'h5000_0000, 4'd7);
        HRDATA = 32'h0000_0077;
        step();
        step();
        step();
        n_checks++;
        if ({HTRANS, HADDR, cmd_ready} !== {2'b11, 32'h5000_0008, 1'b0})
            begin n_fail++; $display("FAIL rm_pre got tr=%b a=%h cr=%b", HTRANS, HADDR, cmd_ready); end
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({HTRANS, HADDR, HWRITE, HBURST, HWDATA, rd_valid, rd_data, done, done_err, wr_ready, cmd_ready}
            !== {2'b00, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL rm_async got tr=%b a=%h b=%b rv=%b cr=%b", HTRANS, HADDR, HBURST, rd_valid, cmd_ready); end
        HRDATA = 32'h0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({HTRANS, done, rd_valid, cmd_ready} !== {2'b00, 1'b0, 1'b0, 1'b1})
                begin n_fail++; $display("FAIL rm_quiet k=%0d got tr=%b d=%b rv=%b cr=%b", k, HTRANS, done, rd_valid, cmd_ready); end
        end
        test_single_read(32'h6000_0013, 32'h1234_5678);
    endtask

    initial begin
        test_reset();
        test_single_read(32'h2000_0004, 32'hDEAD_BEEF);
        test_write_starve();
        test_read_wait();
        test_error();
        test_kb_split();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahblite_master_engine.md
# ahblite_master_engine

Command-driven AHB-Lite bus initiator: accepts one read or write command (start address, beat count), issues word-sized AHB-Lite transfers on the shared bus, streams write data in, and streams read data out. It is the initiator at the other end of the response path, with its HREADY/HRESP/HRDATA inputs driven by the slave response multiplexer. It supports SINGLE and INCR bursts, BUSY insertion on write-data starvation, 1 KB boundary splitting and error abort.

## Interface
- No parameters. HSIZE is fixed at word (3'b010); the data bus is 32 bits.
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low. Clock is HCLK.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle and able to accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  start byte address; bits [1:0] are ignored and forced to 0.
- cmd_len  in  4  number of beats minus 1 (0..15).
- wr_valid  in  1  write word available.
- wr_ready  out  1  write word consumed this cycle when wr_valid is also high.
- wr_data  in  32  write word.
- rd_valid  out  1  read word valid (single-cycle pulse, no backpressure).
- rd_data  out  32  read word.
- done  out  1  single-cycle pulse when the command completes.
- done_err  out  1  qualifies done: 1 = aborted on HRESP error.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  SINGLE (000) when cmd_len = 0, otherwise INCR (001).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  write data, driven in the data phase.
- HREADY  in  1  bus ready (from the response multiplexer).
- HRESP  in  1  bus error response.
- HRDATA  in  32  read data.

## Operation
- **States:**
  - IDLE: cmd_ready = 1.
  - ADDR: address phases remain to be issued.
  - LAST: only the final data phase is outstanding.
  - ERR: second cycle of an error response.
- **IDLE → ADDR** on cmd_valid && cmd_ready. The engine latches the address, direction and remaining = cmd_len + 1. It sets HBURST and HWRITE, and drives HTRANS = IDLE for this first cycle.
- **Address-phase register** (HTRANS/HADDR) updates only when HREADY = 1. In ADDR with HREADY = 1:
  - **Read:** issue the beat. HTRANS = NONSEQ for the first beat or when HADDR[9:0] == 0 (1 KB split); otherwise SEQ.
  - **Write, wr_valid = 1:** issue the beat as for a read. wr_ready = 1 and the popped word is held for the data phase.
  - **Write, wr_valid = 0:** first beat → HTRANS = IDLE; later beats → HTRANS = BUSY, with HADDR already set to the next beat address.
- **wr_ready** = (state == ADDR) && cmd_write && remaining > 0 && HREADY. It is combinational.
- **Beat accounting:** each issued beat increments HADDR by 4 (32-bit wrap) and decrements remaining. After the last beat: ADDR → LAST, and HTRANS returns to IDLE at the next accepted cycle.
- **Data phase:**
  - HWDATA loads the held word when its address phase is accepted (HREADY = 1).
  - Reads capture HRDATA when HREADY = 1 && HRESP = 0 in a data phase.
  - The last data phase completing → done = 1, done_err = 0, and the state returns to IDLE.
- **Error** (HRESP = 1 && HREADY = 0 in a data phase):
  - Next cycle: force HTRANS = IDLE, overriding the hold rule; go to ERR.
  - On HREADY = 1: done = 1, done_err = 1; no rd_valid for the errored beat; remaining beats are dropped; go to IDLE.
  - Unconsumed write words stay with the producer.
- **Reset mid-burst:** all state returns to reset values immediately; no done is generated.

## Timing
- **Reset values:**
  - HTRANS = 00, HADDR = 0, HWRITE = 0, HBURST = 0, HWDATA = 0.
  - rd_valid = 0, rd_data = 0, done = 0, done_err = 0, wr_ready = 0.
  - cmd_ready = 1; state IDLE.
- **Single read, zero wait**, command accepted in cycle T:
  - T+1: HTRANS = IDLE.
  - T+2: HTRANS = NONSEQ.
  - T+3: data phase.
  - T+4: rd_valid, done, cmd_ready = 1.
- **N-beat read, no waits:** beats in T+2..T+N+1; rd_valid in T+4..T+N+3; done with the last rd_valid.
- **Wait states:** each HREADY = 0 cycle extends all of the above by one cycle. HADDR, HTRANS and HWDATA are held stable while HREADY = 0.
- **rd_valid** is registered: one cycle after the completing data-phase edge.
- **done** is registered: same cycle as the final rd_valid (reads); one cycle after the final write data phase completes (writes).
- **Back-to-back commands:** minimum one IDLE bus cycle between commands.

## Test plan
- **Single read, zero wait:** cmd_addr = 0x2000_0004, len 0, HRDATA = 0xDEAD_BEEF → HTRANS NONSEQ at T+2 with HBURST = 000; rd_valid with 0xDEAD_BEEF and done at T+4.
- **4-beat write with a starvation gap:** wr_valid low for one cycle after beat 1 → HTRANS sequence NONSEQ, BUSY, SEQ, SEQ, SEQ. HADDR during BUSY = 0x…04. HWDATA sequence matches the words; done_err = 0.
- **Read with two wait states on beat 2 of 3:** HADDR and HTRANS held for 2 cycles; three rd_valid pulses in order; done is delayed by 2 cycles.
- **Error:** HRESP = 1 on beat 2 of a 4-beat read → next cycle HTRANS = IDLE; done = 1, done_err = 1; exactly one rd_valid; no further NONSEQ/SEQ.
- **1 KB split:** cmd_addr = 0x0000_03F8, len 3 → HTRANS NONSEQ, SEQ, NONSEQ (at 0x400), SEQ.
- **Reset asserted mid-burst** (beat 3 of 8) → all outputs return to reset values asynchronously; cmd_ready = 1 after release; the next command runs normally.
